// File: rtl/input_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
// Shared constants and helpers for the board-interface input blocks
// (debouncers, prescalers and scanners).
//   DEBOUNCE_COUNTER_BITS : default width of a per-channel stability counter
//   DEBOUNCE_TICK_DIV     : default clock cycles per scan slot
//   idx_width(n)          : bits needed to index n items, never less than 1
// -----------------------------------------------------------------------------
package input_pkg;

    localparam int DEBOUNCE_COUNTER_BITS = 5;
    localparam int DEBOUNCE_TICK_DIV     = 16;

    // $clog2(1) is 0, so clamp to 1 to avoid zero-width vectors.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-cycle tick every DIV clock cycles.
// The counter runs 0..DIV-1 and tick is high while it holds DIV-1.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous, active-low reset (counter cleared to 0)
//   tick    : high for one cycle out of every DIV
// -----------------------------------------------------------------------------
module tick_prescaler
    import input_pkg::*;
#(
    parameter int DIV = DEBOUNCE_TICK_DIV
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int            CW   = idx_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    // With DIV=1 LAST is 0, so the counter sits at 0 and tick stays high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/debounce_scanner.sv
// -----------------------------------------------------------------------------
// debounce_scanner
// Time-multiplexed debouncer. A single compare/increment step is shared
// round-robin across CHANNELS synchronized inputs, one channel per prescaler
// tick. A channel's level changes only after 2^COUNTER_BITS consecutive
// services in which its input differed from the current level; any matching
// service restarts its count.
// Ports:
//   clock    : system clock
//   reset_n  : asynchronous, active-low reset
//   in       : raw asynchronous inputs, active-high
//   level    : debounced level per channel
//   pressed  : one-cycle pulse after a debounced 0->1 change
//   released : one-cycle pulse after a debounced 1->0 change
//   scan_idx : channel serviced on the next tick (debug)
// -----------------------------------------------------------------------------
module debounce_scanner
    import input_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int COUNTER_BITS = DEBOUNCE_COUNTER_BITS,
    parameter int TICK_DIV     = DEBOUNCE_TICK_DIV
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [CHANNELS-1:0]              in,
    output logic [CHANNELS-1:0]              level,
    output logic [CHANNELS-1:0]              pressed,
    output logic [CHANNELS-1:0]              released,
    output logic [idx_width(CHANNELS)-1:0]   scan_idx
);

    localparam int            IW       = idx_width(CHANNELS);
    localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);

    logic [CHANNELS-1:0]                   r_sync1;
    logic [CHANNELS-1:0]                   r_sync2;
    logic [CHANNELS-1:0]                   r_level;
    logic [CHANNELS-1:0]                   r_pressed;
    logic [CHANNELS-1:0]                   r_released;
    logic [CHANNELS-1:0][COUNTER_BITS-1:0] r_count;
    logic [IW-1:0]                         r_scan_idx;

    logic                                  w_tick;
    logic [CHANNELS-1:0]                   w_service;
    logic [CHANNELS-1:0]                   w_differs;
    logic [CHANNELS-1:0]                   w_saturated;

    tick_prescaler #(
        .DIV     (TICK_DIV)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    // Two-flop synchronizer; r_sync2 is the only consumer-visible copy of in.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    // Round-robin pointer; explicit wrap so non-power-of-2 counts never
    // visit an index past CHANNELS-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_idx <= '0;
        end else if (w_tick) begin
            r_scan_idx <= (r_scan_idx == LAST_IDX) ? '0 : r_scan_idx + 1'b1;
        end
    end

    // Per-channel decode of the shared compare step.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign w_service[gi]   = w_tick && (r_scan_idx == IW'(gi));
            assign w_differs[gi]   = r_sync2[gi] ^ r_level[gi];
            assign w_saturated[gi] = &r_count[gi];
        end
    endgenerate

    // All-ones count is terminal: the next differing service accepts the new
    // level instead of wrapping. Pulses default low, so they last one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_level    <= '0;
            r_pressed  <= '0;
            r_released <= '0;
        end else begin
            r_pressed  <= '0;
            r_released <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_service[c]) begin
                    if (!w_differs[c]) begin
                        r_count[c] <= '0;
                    end else if (!w_saturated[c]) begin
                        r_count[c] <= r_count[c] + 1'b1;
                    end else begin
                        r_count[c]    <= '0;
                        r_level[c]    <= r_sync2[c];
                        r_pressed[c]  <= r_sync2[c];
                        r_released[c] <= ~r_sync2[c];
                    end
                end
            end
        end
    end

    assign level    = r_level;
    assign pressed  = r_pressed;
    assign released = r_released;
    assign scan_idx = r_scan_idx;

endmodule

// File: tb/tb_debounce_scanner.sv
// -----------------------------------------------------------------------------
// tb_debounce_scanner
// Two instances: CHANNELS=4 (P=8) and CHANNELS=3 (P=6), both with
// COUNTER_BITS=2 and TICK_DIV=2. A cycle-level reference model derived from
// the acceptance rule (run of 2^COUNTER_BITS differing services) is compared
// against every output every cycle, alongside a vector table and directed
// latency / glitch / reset sequences, then randomized segments.
// -----------------------------------------------------------------------------
module tb_debounce_scanner;
    import input_pkg::*;

    localparam int CB  = 2;
    localparam int TD  = 2;
    localparam int ACC = 1 << CB;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in4     = '0;
    logic [2:0] in3     = '0;
    logic [3:0] level4, pressed4, released4;
    logic [1:0] idx4;
    logic [2:0] level3, pressed3, released3;
    logic [1:0] idx3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    debounce_scanner #(.CHANNELS(4), .COUNTER_BITS(CB), .TICK_DIV(TD)) dut4 (
        .clock    (clock),
        .reset_n  (reset_n),
        .in       (in4),
        .level    (level4),
        .pressed  (pressed4),
        .released (released4),
        .scan_idx (idx4)
    );

    debounce_scanner #(.CHANNELS(3), .COUNTER_BITS(CB), .TICK_DIV(TD)) dut3 (
        .clock    (clock),
        .reset_n  (reset_n),
        .in       (in3),
        .level    (level3),
        .pressed  (pressed3),
        .released (released3),
        .scan_idx (idx3)
    );

    // ---------------- reference model (index 0: 4 ch, 1: 3 ch) ----------------
    logic [3:0] m_s1 [2];
    logic [3:0] m_s2 [2];
    logic [3:0] m_lvl[2];
    logic [3:0] m_pr [2];
    logic [3:0] m_rl [2];
    int         m_k  [2];
    int         m_idx[2];
    int         m_run[2][4];

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    // Edge k since reset: tick when k mod TD == TD-1; that tick serves
    // channel (k/TD) mod N using the input seen two edges earlier.
    task automatic model_edge(input int d, input logic [3:0] raw);
        if (!reset_n) begin
            m_s1[d] = '0; m_s2[d] = '0; m_lvl[d] = '0;
            m_pr[d] = '0; m_rl[d] = '0; m_k[d] = 0; m_idx[d] = 0;
            for (int c = 0; c < 4; c++) m_run[d][c] = 0;
        end else begin
            m_pr[d] = '0;
            m_rl[d] = '0;
            if (m_k[d] % TD == TD - 1) begin
                int c;
                c = (m_k[d] / TD) % nch(d);
                if (m_s2[d][c] != m_lvl[d][c]) begin
                    m_run[d][c]++;
                    if (m_run[d][c] == ACC) begin
                        m_lvl[d][c] = m_s2[d][c];
                        m_pr[d][c]  = m_s2[d][c];
                        m_rl[d][c]  = ~m_s2[d][c];
                        m_run[d][c] = 0;
                    end
                end else begin
                    m_run[d][c] = 0;
                end
            end
            m_idx[d] = ((m_k[d] + 1) / TD) % nch(d);
            m_s2[d]  = m_s1[d];
            m_s1[d]  = raw;
            m_k[d]++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        chk("level4",    level4,    m_lvl[0]);
        chk("pressed4",  pressed4,  m_pr[0]);
        chk("released4", released4, m_rl[0]);
        chk("scan_idx4", idx4,      m_idx[0]);
        chk("level3",    level3,    m_lvl[1][2:0]);
        chk("pressed3",  pressed3,  m_pr[1][2:0]);
        chk("released3", released3, m_rl[1][2:0]);
        chk("scan_idx3", idx3,      m_idx[1]);
        chk("one_pulse4", ($countones(pressed4) + $countones(released4)) <= 1, 1);
        chk("idx3_range", idx3 < 2'd3, 1);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge,
    // new stimulus applied by the caller after return.
    task automatic tick_cycle();
        @(posedge clock);
        model_edge(0, in4);
        model_edge(1, {1'b0, in3});
        @(negedge clock);
        compare_all();
        cyc++;
    endtask

    function automatic logic lvl_bit(input int d, input int ch);
        return (d == 0) ? level4[ch] : level3[ch];
    endfunction

    function automatic logic pulse_bit(input int d, input int ch, input logic v);
        if (d == 0) return v ? pressed4[ch] : released4[ch];
        return v ? pressed3[ch] : released3[ch];
    endfunction

    // Counts edges from stimulus until the level bit reaches v; the pulse
    // must coincide with that first cycle.
    task automatic wait_level(input int d, input int ch, input logic v,
                              input int lo, input int hi, input string name);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        for (int i = 1; i <= hi + 4; i++) begin
            tick_cycle();
            if (!seen && lvl_bit(d, ch) == v) begin
                seen = 1;
                n    = i;
                chk({name, "_pulse"}, pulse_bit(d, ch, v), 1);
            end
        end
        chk({name, "_latency"}, seen && n >= lo && n <= hi, 1);
        $display("%s: dut%0d ch%0d -> %0b after %0d cycles (window %0d..%0d)",
                 name, nch(d), ch, v, n, lo, hi);
    endtask

    typedef struct {
        logic [3:0] in_v;
        int         cycles;
        logic [3:0] exp_level;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{4'b0000, 200, 4'b0000};
        vecs[1] = '{4'b0110,  40, 4'b0110};
        vecs[2] = '{4'b0010,  40, 4'b0010};
        vecs[3] = '{4'b1011,  40, 4'b1011};
        vecs[4] = '{4'b0000,  40, 4'b0000};

        // Reset state.
        repeat (3) tick_cycle();
        chk("rst_level",    level4,   0);
        chk("rst_pressed",  pressed4, 0);
        chk("rst_released", released4, 0);
        chk("rst_idx",      idx4,     0);
        $display("reset: level=%b idx=%0d", level4, idx4);
        reset_n = 1'b1;

        // Vector table: hold each pattern long enough to settle.
        for (int v = 0; v < 5; v++) begin
            in4 = vecs[v].in_v;
            in3 = vecs[v].in_v[2:0];
            for (int i = 0; i < vecs[v].cycles; i++) tick_cycle();
            chk("vec_level4", level4, vecs[v].exp_level);
            chk("vec_level3", level3, {1'b0, vecs[v].exp_level[2:0]} & 4'h7);
            $display("vector %0d: in=%b level4=%b level3=%b", v, vecs[v].in_v, level4, level3);
        end

        // Clean press/release, P=8 then P=6.
        in4[2] = 1'b1;
        wait_level(0, 2, 1'b1, 2 + 25, 2 + 32, "press4");
        in4[2] = 1'b0;
        wait_level(0, 2, 1'b0, 2 + 25, 2 + 32, "release4");
        in3[2] = 1'b1;
        wait_level(1, 2, 1'b1, 2 + 19, 2 + 24, "press3");
        in3[2] = 1'b0;
        wait_level(1, 2, 1'b0, 2 + 19, 2 + 24, "release3");

        // Glitch rejection on channel 1 of the 4-channel instance.
        begin
            bit pulse_seen;
            pulse_seen = 0;
            for (int r = 0; r < 10; r++) begin
                in4[1] = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    tick_cycle();
                    if ((pressed4 | released4) != 0 || level4[1]) pulse_seen = 1;
                end
                in4[1] = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    tick_cycle();
                    if ((pressed4 | released4) != 0 || level4[1]) pulse_seen = 1;
                end
            end
            chk("glitch_reject", pulse_seen, 0);
            $display("glitch: 10 bursts of 20 cycles on ch1, level4=%b", level4);
        end

        // Simultaneous press on channels 0 and 3.
        begin
            int t0, t3;
            t0 = 0;
            t3 = 0;
            in4[0] = 1'b1;
            in4[3] = 1'b1;
            for (int i = 1; i <= 40; i++) begin
                tick_cycle();
                if (t0 == 0 && level4[0]) t0 = i;
                if (t3 == 0 && level4[3]) t3 = i;
            end
            chk("simul_lat0", t0 >= 27 && t0 <= 34, 1);
            chk("simul_lat3", t3 >= 27 && t3 <= 34, 1);
            chk("simul_distinct", t0 != t3, 1);
            $display("simultaneous: ch0 after %0d, ch3 after %0d cycles", t0, t3);
            in4 = '0;
            repeat (40) tick_cycle();
        end

        // Reset in the middle of a count.
        in4[0] = 1'b1;
        repeat (20) tick_cycle();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_cycle();
            chk("midrst_pulse", pressed4 | released4, 0);
            chk("midrst_level", level4, 0);
        end
        reset_n = 1'b1;
        wait_level(0, 0, 1'b1, 2 + 25, 2 + 32, "post_reset4");
        in4 = '0;
        repeat (40) tick_cycle();

        // Randomized segments with occasional resets.
        for (int s = 0; s < 60; s++) begin
            int hold;
            in4  = 4'($urandom);
            in3  = 3'($urandom);
            hold = $urandom_range(1, 40);
            if ($urandom_range(0, 19) == 0) reset_n = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick_cycle();
                reset_n = 1'b1;
            end
            $display("random %0d: in4=%b in3=%b hold=%0d level4=%b level3=%b",
                     s, in4, in3, hold, level4, level3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
